// File: rtl/nibble_load_seq_if.sv
// Serial-in / parallel-load link between the frame receiver and the downstream register.
interface nibble_load_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             sin;
  logic             sin_valid;
  logic [1:0]       PE;
  logic [WIDTH-1:0] D;
  logic             busy;
  logic             perr;

  modport master (output sin, sin_valid, input  PE, D, busy, perr);
  modport slave  (input  sin, sin_valid, output PE, D, busy, perr);
endinterface

// File: rtl/nibble_load_seq.sv
// Framed serial receiver: assembles WIDTH data bits, checks optional parity and
// issues a one-cycle registered load (PE=11, D=word) to the downstream register.
module nibble_load_seq #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              r,
  nibble_load_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, LOAD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [1:0]       pe_q, pe_d;
  logic             perr_q, perr_d;
  logic             perr_n_q, perr_n_d;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      d_q      <= '0;
      pe_q     <= 2'b00;
      perr_q   <= 1'b0;
      perr_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      d_q      <= d_d;
      pe_q     <= pe_d;
      perr_q   <= perr_d;
      perr_n_q <= perr_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    d_d      = d_q;
    perr_d   = perr_q;
    perr_n_d = perr_n_q;
    unique case (state_q)
      IDLE: if (bus.sin_valid && !bus.sin) begin
        state_d  = DATA;
        cnt_d    = '0;
        perr_d   = 1'b0;
        perr_n_d = 1'b0;
      end
      DATA: if (bus.sin_valid) begin
        if (LSB_FIRST != 0) begin
          sh_d = sh_q >> 1;
          sh_d[WIDTH-1] = bus.sin;
        end else begin
          sh_d = sh_q << 1;
          sh_d[0] = bus.sin;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = (PARITY_EN != 0) ? PAR : STOP;
      end
      PAR: if (bus.sin_valid) begin
        // Expected parity bit is the data XOR, flipped for odd parity.
        perr_n_d = bus.sin != ((^sh_q) ^ (PARITY_ODD != 0));
        state_d  = STOP;
      end
      STOP: if (bus.sin_valid) begin
        if (bus.sin && !perr_n_q) begin
          state_d = LOAD;
          d_d     = sh_q;
        end else begin
          state_d = IDLE;
          perr_d  = 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // PE is registered so it is high exactly while the FSM sits in LOAD.
    pe_d = (state_d == LOAD) ? 2'b11 : 2'b00;
  end

  assign bus.PE   = pe_q;
  assign bus.D    = d_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.perr = perr_q;

endmodule

// File: tb/tb_nibble_load_seq.sv
// Directed bench for nibble_load_seq: expected loads queued at stimulus time, popped on PE=11.
module tb_nibble_load_seq;
  logic clk = 1'b0;
  logic r;
  nibble_load_seq_if #(.WIDTH(4)) bus ();

  nibble_load_seq #(.WIDTH(4), .PARITY_EN(1), .PARITY_ODD(0), .LSB_FIRST(1)) dut (
    .clk(clk),
    .r  (r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         nchk  = 0;
  int         npass = 0;
  int         nloads = 0;
  logic [3:0] exp_q[$];
  logic [1:0] prev_pe = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Load monitor: every PE=11 cycle must match the oldest queued word.
  always @(negedge clk) begin
    check("pe_legal", 32'(bus.PE == 2'b00 || bus.PE == 2'b11), 1);
    if (bus.PE == 2'b11) begin
      check("pe_single_cycle", 32'(prev_pe), 0);
      check("load_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("load_D", 32'(bus.D), 32'(exp_q.pop_front()));
      nloads++;
    end
    prev_pe = bus.PE;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int gaps);
    repeat (gaps) @(negedge clk);
    @(negedge clk);
    bus.sin_valid = 1'b1;
    bus.sin       = b;
    @(negedge clk);
    bus.sin_valid = 1'b0;
    bus.sin       = 1'b1;
  endtask

  // seq[i] is the i-th data bit on the wire.
  task automatic send_frame(input logic [3:0] seq, input logic par, input logic stp,
                            input int gaps, input bit chk_busy);
    send_bit(1'b0, gaps);
    if (chk_busy) check("busy_start", 32'(bus.busy), 1);
    for (int i = 0; i < 4; i++) begin
      send_bit(seq[i], gaps);
      if (chk_busy) check("busy_data", 32'(bus.busy), 1);
    end
    send_bit(par, gaps);
    if (chk_busy) check("busy_par", 32'(bus.busy), 1);
    send_bit(stp, gaps);
    if (chk_busy) check("busy_load", 32'(bus.busy), 1);
  endtask

  initial begin
    r = 1'b0;
    bus.sin = 1'b1;
    bus.sin_valid = 1'b0;
    idle(3);
    check("rst_PE", 32'(bus.PE), 0);
    check("rst_D", 32'(bus.D), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_perr", 32'(bus.perr), 0);

    // Idle line after reset release
    r = 1'b1;
    bus.sin_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_PE", 32'(bus.PE), 0);
      check("idle_D", 32'(bus.D), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_perr", 32'(bus.perr), 0);
    end
    bus.sin_valid = 1'b0;

    // Good even-parity frame, data 1,0,1,1
    exp_q.push_back(4'b1101);
    send_frame(4'b1101, 1'b1, 1'b1, 0, 1'b0);
    idle(2);
    check("good_loads", nloads, 1);
    check("good_D", 32'(bus.D), 4'hD);
    check("good_perr", 32'(bus.perr), 0);

    // Wrong parity bit: no load, perr sticky
    send_frame(4'b1101, 1'b0, 1'b1, 0, 1'b0);
    idle(3);
    check("par_loads", nloads, 1);
    check("par_D_hold", 32'(bus.D), 4'hD);
    check("par_perr", 32'(bus.perr), 1);
    check("par_busy", 32'(bus.busy), 0);

    // Next start bit clears perr; this frame then has a bad stop bit
    send_bit(1'b0, 0);
    check("start_clr_perr", 32'(bus.perr), 0);
    for (int i = 0; i < 4; i++) send_bit(4'b1101 >> i, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    idle(2);
    check("frm_loads", nloads, 1);
    check("frm_perr", 32'(bus.perr), 1);
    check("frm_busy", 32'(bus.busy), 0);
    check("frm_D_hold", 32'(bus.D), 4'hD);

    // Recovery frame, data 0,1,1,0
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    idle(2);
    check("rec_loads", nloads, 2);
    check("rec_D", 32'(bus.D), 4'h6);
    check("rec_perr", 32'(bus.perr), 0);

    // Gapped frame, data 0,0,0,1, three idle cycles before each bit
    exp_q.push_back(4'b1000);
    send_frame(4'b1000, 1'b1, 1'b1, 2, 1'b1);
    @(negedge clk);
    check("gap_busy_after", 32'(bus.busy), 0);
    idle(1);
    check("gap_loads", nloads, 3);
    check("gap_D", 32'(bus.D), 4'h8);

    // Reset after two data bits
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    r = 1'b0;
    idle(2);
    check("mid_rst_PE", 32'(bus.PE), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_D", 32'(bus.D), 0);
    check("mid_rst_perr", 32'(bus.perr), 0);
    r = 1'b1;
    idle(2);
    check("mid_rst_loads", nloads, 3);
    exp_q.push_back(4'b1111);
    send_frame(4'b1111, 1'b0, 1'b1, 0, 1'b0);
    idle(3);
    check("post_rst_loads", nloads, 4);
    check("post_rst_D", 32'(bus.D), 4'hF);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/nibble_load_seq.md
Name: nibble_load_seq

Overview:
- Upstream feeder for the 4-bit parallel-load register stage.
- Receives a framed serial bit stream, assembles a WIDTH-bit word and checks optional parity.
- Presents the word on D, with a one-cycle load code on PE, so the downstream register captures it.
- Drives on the rising clk edge. The downstream register samples on the falling edge, so D/PE are stable for half a cycle before capture.

Parameters:
- WIDTH, 4, data bits per frame; must match the downstream register width.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN=0.
- LSB_FIRST, 1, 1 = first data bit received lands in D[0]; 0 = first lands in D[WIDTH-1].

Ports:
- clk  in  1  clock, rising-edge active
- r  in  1  reset, asynchronous, active-low
- sin  in  1  serial data bit
- sin_valid  in  1  sin carries a bit this cycle
- PE  out  2  load code to downstream: 2'b11 = load, 2'b00 = hold
- D  out  WIDTH  assembled word to downstream
- busy  out  1  frame in progress (state != IDLE)
- perr  out  1  parity error on the last frame; sticky until next start bit

Behaviour:
- Reset (r=0, asynchronous):
  - state=IDLE, PE=2'b00, D=0, busy=0, perr=0.
  - Shift register and bit counter cleared.
  - Reset mid-frame discards the partial word; no load is issued.
- Input qualification: only cycles with sin_valid=1 advance the FSM. Cycles with sin_valid=0 leave all state unchanged; gaps inside a frame are legal.
- States:
  - IDLE:
    - sin_valid & sin=0 (start bit) -> DATA; cnt=0; perr cleared.
    - sin_valid & sin=1 -> stay in IDLE (line idle).
  - DATA:
    - Each valid bit is shifted into the assembly register per LSB_FIRST; cnt increments.
    - On the WIDTH-th bit: if PARITY_EN -> PAR, else -> STOP.
  - PAR:
    - The valid bit is compared to the XOR of the data bits, inverted when PARITY_ODD.
    - Mismatch sets the internal flag perr_n. Next state STOP.
  - STOP:
    - Valid bit=1 and no parity error -> LOAD.
    - Valid bit=1 with parity error -> IDLE, perr=1, no load.
    - Valid bit=0 (framing error) -> IDLE, perr=1, no load.
  - LOAD (exactly 1 cycle, independent of sin_valid):
    - D <= assembled word; PE=2'b11 for this cycle only. Next state IDLE.
    - A sin_valid bit arriving in this cycle is ignored; the sender must not begin the next start bit until the cycle after LOAD.
- Outputs:
  - D is registered and holds its value between frames; it changes only in LOAD.
  - PE is 2'b00 in every state except LOAD. Codes 2'b01 and 2'b10 are never driven.
- Latency: the LOAD cycle is the first rising edge after the stop bit is accepted. The downstream register captures on the following falling edge, 0.5 cycle later.
- busy=1 in DATA, PAR, STOP and LOAD.
- Counter width is clog2(WIDTH+1); it never wraps within a frame.
- PE and D are registered outputs (glitch-free), required because the downstream register uses PE as a load enable.

Test Plan:
- Reset then idle: hold r=0, then release with sin=1, sin_valid=1 for 10 cycles -> PE=00, D=0, busy=0, perr=0 throughout.
- Even-parity frame, LSB_FIRST=1: send start 0, data 1,0,1,1, parity 1, stop 1 -> one cycle with PE=11 and D=4'b1101; PE=00 the cycle after; perr=0.
- Same frame with parity bit 0 -> no PE=11 pulse, D keeps its previous value, perr=1 until the next start bit, which clears perr to 0.
- Framing error: valid frame except stop bit=0 -> no load, perr=1, return to IDLE; the next good frame with data 0,1,1,0 gives D=4'b0110.
- Gapped input: insert 3 sin_valid=0 cycles between each bit of data 0,0,0,1 -> PE=11 once with D=4'b1000; busy high from the start bit through the LOAD cycle.
- Reset mid-frame: drop r after 2 data bits, release, then send a full frame with data 1,1,1,1 -> PE=11 once with D=4'b1111; no spurious load at or after reset.
